// File: rtl/ddr_pkg.sv
// Shared widths, output FIFO depth and packer state encoding for the
// DDR nibble receive path.
package ddr_pkg;
  localparam int NIB_W       = 4;
  localparam int BYTE_W      = 8;
  localparam int OFIFO_DEPTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pk_state_e;
endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with a registered head; dout never sees din combinationally.
// Handshake: a push is taken only while not full or with a same-edge pop; a pop
// while empty is ignored.
module word_fifo2
  import ddr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   level,
  output logic         full
);
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   level_q, level_d;
  logic         do_push, do_pop;

  assign full  = (level_q == 2'(OFIFO_DEPTH));
  assign level = level_q;
  assign dout  = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    do_pop  = pop && (level_q != 2'd0);
    do_push = push && (!full || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (level_q == 2'd0) head_d = din;
        else                 tail_d = din;
        level_d = level_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        level_d = level_q - 2'd1;
      end
      2'b11: begin
        // Level is unchanged; with two entries the tail moves up to head.
        if (level_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/ddr_nibble_packer.sv
// Joins DDR nibble pairs into bytes, packs WORD_BYTES bytes little-endian into
// a word and queues words in a 2-entry FIFO behind a valid/ready output.
module ddr_nibble_packer
  import ddr_pkg::*;
#(
  parameter int WORD_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NIB_W-1:0]             din_lo,
  input  logic [NIB_W-1:0]             din_hi,
  input  logic                         din_valid,
  input  logic                         sof,
  output logic [BYTE_W*WORD_BYTES-1:0] dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   level,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic                         state_dbg
);
  localparam int WW = BYTE_W * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  pk_state_e         state_q, state_d;
  logic [BW-1:0]     bidx_q, bidx_d, idx;
  logic [WW-1:0]     asm_q, asm_d;
  logic              ovf_q, ovf_d;
  logic [BYTE_W-1:0] byte_in;
  logic              word_done, push, pop, full;

  assign byte_in   = {din_hi, din_lo};
  assign out_valid = (level != 2'd0);
  assign overflow  = ovf_q;
  assign state_dbg = (state_q == FILL);
  assign pop       = out_valid && out_ready;
  assign push      = word_done && (!full || pop);

  always_comb begin
    asm_d     = asm_q;
    bidx_d    = bidx_q;
    state_d   = state_q;
    word_done = 1'b0;
    // sof realigns the incoming byte to slot 0 and drops any partial word.
    idx       = sof ? '0 : bidx_q;
    if (din_valid) begin
      if (sof) asm_d = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (BW'(k) == idx) asm_d[BYTE_W*k +: BYTE_W] = byte_in;
      end
      word_done = (idx == BW'(WORD_BYTES - 1));
      bidx_d    = word_done ? '0 : idx + BW'(1);
      state_d   = word_done ? IDLE : FILL;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (word_done && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bidx_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
    end
  end

  // The completed word includes the byte landing this edge, so push asm_d.
  word_fifo2 #(.W(WW)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (asm_d),
    .dout  (dout),
    .level (level),
    .full  (full)
  );
endmodule

// File: tb/tb_ddr_nibble_packer.sv
// Directed bench for ddr_nibble_packer with WORD_BYTES=2: reset, packing,
// sof realign, overflow, full push+pop and gapped input.
module tb_ddr_nibble_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din_lo, din_hi;
  logic        din_valid, sof, out_ready, clr_ovf;
  logic [15:0] dout;
  logic        out_valid, overflow, state_dbg;
  logic [1:0]  level;
  int checks = 0;
  int errors = 0;

  ddr_nibble_packer #(.WORD_BYTES(2)) dut (
    .clk(clk), .rst(rst), .din_lo(din_lo), .din_hi(din_hi),
    .din_valid(din_valid), .sof(sof), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .clr_ovf(clr_ovf), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b, input logic s);
    @(negedge clk);
    din_lo = b[3:0]; din_hi = b[7:4]; din_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0 || overflow !== 1'b0 || dout !== 16'h0) begin
      errors++; $display("FAIL reset_init got v=%b l=%0d o=%b d=%h exp 0 0 0 0000", out_valid, level, overflow, dout); end
    out_ready = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h77, 0);
    checks++; if (overflow !== 1'b1 || level !== 2'd2) begin
      errors++; $display("FAIL reset_pre got o=%b l=%0d exp 1 2", overflow, level); end
    rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || level !== 2'd0 || overflow !== 1'b0 || dout !== 16'h0 || state_dbg !== 1'b0) begin
      errors++; $display("FAIL reset_async got v=%b l=%0d o=%b d=%h s=%b exp 0 0 0 0000 0", out_valid, level, overflow, dout, state_dbg); end
    @(negedge clk); rst = 1'b1;
    send_byte(8'h12, 0);
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_partial got v=%b exp 0", out_valid); end
    send_byte(8'h34, 0);
    checks++; if (out_valid !== 1'b1 || dout !== 16'h3412 || level !== 2'd1) begin
      errors++; $display("FAIL reset_fresh got v=%b d=%h l=%0d exp 1 3412 1", out_valid, dout, level); end
    pop_one();
    checks++; if (level !== 2'd0) begin
      errors++; $display("FAIL reset_drain got l=%0d exp 0", level); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_byte(8'h3A, 0);
    checks++; if (state_dbg !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_fill got s=%b v=%b exp 1 0", state_dbg, out_valid); end
    send_byte(8'hC5, 0);
    checks++; if (out_valid !== 1'b1 || dout !== 16'hC53A || level !== 2'd1 || state_dbg !== 1'b0) begin
      errors++; $display("FAIL basic_word got v=%b d=%h l=%0d s=%b exp 1 c53a 1 0", out_valid, dout, level, state_dbg); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin
      errors++; $display("FAIL basic_onecycle got v=%b l=%0d exp 0 0", out_valid, level); end
    out_ready = 1'b0;
  endtask

  task automatic test_sof();
    out_ready = 1'b1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    checks++; if (out_valid !== 1'b0 || state_dbg !== 1'b1) begin
      errors++; $display("FAIL sof_nopush got v=%b s=%b exp 0 1", out_valid, state_dbg); end
    send_byte(8'h33, 0);
    checks++; if (out_valid !== 1'b1 || dout !== 16'h3322) begin
      errors++; $display("FAIL sof_word got v=%b d=%h exp 1 3322", out_valid, dout); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sof_extra got v=%b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    checks++; if (level !== 2'd2 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full got l=%0d o=%b exp 2 0", level, overflow); end
    send_byte(8'h05, 0); send_byte(8'h06, 0);
    checks++; if (level !== 2'd2 || overflow !== 1'b1 || dout !== 16'h0201) begin
      errors++; $display("FAIL ovf_drop got l=%0d o=%b d=%h exp 2 1 0201", level, overflow, dout); end
    pop_one();
    checks++; if (dout !== 16'h0403 || level !== 2'd1) begin
      errors++; $display("FAIL ovf_pop1 got d=%h l=%0d exp 0403 1", dout, level); end
    pop_one();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_pop2 got v=%b l=%0d o=%b exp 0 0 1", out_valid, level, overflow); end
    @(negedge clk); clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got o=%b exp 0", overflow); end
    send_byte(8'h0A, 0); send_byte(8'h0B, 0);
    send_byte(8'h0C, 0); send_byte(8'h0D, 0);
    send_byte(8'h0E, 0);
    clr_ovf = 1'b1;
    send_byte(8'h0F, 0);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1 || dout !== 16'h0B0A) begin
      errors++; $display("FAIL ovf_setwins got o=%b d=%h exp 1 0b0a", overflow, dout); end
    pop_one();
    checks++; if (dout !== 16'h0D0C) begin
      errors++; $display("FAIL ovf_order got d=%h exp 0d0c", dout); end
    pop_one();
    @(negedge clk); clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
  endtask

  task automatic test_full_pushpop();
    out_ready = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h07, 0);
    out_ready = 1'b1;
    send_byte(8'h08, 0);
    out_ready = 1'b0;
    checks++; if (level !== 2'd2 || dout !== 16'h0403 || overflow !== 1'b0) begin
      errors++; $display("FAIL pp_same got l=%0d d=%h o=%b exp 2 0403 0", level, dout, overflow); end
    idle_cycle();
    checks++; if (dout !== 16'h0403 || level !== 2'd2) begin
      errors++; $display("FAIL pp_stable got d=%h l=%0d exp 0403 2", dout, level); end
    pop_one();
    checks++; if (dout !== 16'h0807 || level !== 2'd1) begin
      errors++; $display("FAIL pp_last got d=%h l=%0d exp 0807 1", dout, level); end
    pop_one();
    checks++; if (level !== 2'd0) begin
      errors++; $display("FAIL pp_empty got l=%0d exp 0", level); end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    send_byte(8'h44, 0);
    @(negedge clk); sof = 1'b1;
    @(posedge clk); #1; sof = 1'b0;
    idle_cycle();
    checks++; if (out_valid !== 1'b0 || state_dbg !== 1'b1) begin
      errors++; $display("FAIL gap_wait got v=%b s=%b exp 0 1", out_valid, state_dbg); end
    send_byte(8'h55, 0);
    checks++; if (out_valid !== 1'b1 || dout !== 16'h5544) begin
      errors++; $display("FAIL gap_word got v=%b d=%h exp 1 5544", out_valid, dout); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_pop got v=%b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din_lo = '0; din_hi = '0; din_valid = 1'b0; sof = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_sof();
    test_overflow();
    test_full_pushpop();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_nibble_packer.md
# ddr_nibble_packer

Receive-side stage directly downstream of the dual-edge capture flop. Takes the two 4-bit nibbles captured per clock (rising-edge and falling-edge halves), joins them into bytes and packs `WORD_BYTES` bytes into one word. Words are held in a 2-entry output FIFO behind a valid/ready handshake. Sits between the DDR capture flops and the word-level consumer logic.

## Interface
- `WORD_BYTES`, default 2: bytes per output word. Legal range 2–8.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `din_lo` input 4: nibble captured on the rising edge. Low half of the byte.
- `din_hi` input 4: nibble captured on the falling edge of the same cycle. High half of the byte.
- `din_valid` input 1: the nibble pair is valid this cycle.
- `sof` input 1: start of frame. Qualified by `din_valid`.
- `dout` output 8*WORD_BYTES: head word of the FIFO.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts the head word.
- `level` output 2: FIFO occupancy, 0–2.
- `overflow` output 1: sticky; set when a completed word is dropped.
- `clr_ovf` input 1: clears `overflow`.

## Operation
- Byte formation: byte = {`din_hi`, `din_lo`}. Bytes are formed only on cycles with `din_valid`=1.
- Assembly:
  - Byte index counter `bidx` runs 0..WORD_BYTES-1.
  - Byte k is written to bits [8k+7:8k] of the assembly register. First byte is least significant (little-endian).
- State machine:
  - IDLE (`bidx`=0, nothing held) goes to FILL on the first valid byte.
  - FILL returns to IDLE when byte WORD_BYTES-1 is written. That byte completes the word, which is pushed to the FIFO on the same edge.
- `sof`:
  - `sof`=1 with `din_valid`=1 forces this byte to be byte 0 and discards any partial word silently.
  - `sof` without `din_valid` is ignored.
- FIFO:
  - Push when a word completes and (`level`<2 or a pop occurs on the same edge).
  - Pop when `out_valid` and `out_ready` are both 1.
  - Push and pop on the same edge when full: both happen, `level` stays 2, and order is preserved.
- Overflow:
  - A completed word arriving while `level`=2 and no pop occurs is dropped. `overflow` is set to 1.
  - The assembly counter still restarts at 0.
  - `clr_ovf` clears `overflow`. If `clr_ovf` coincides with a new drop, set wins.
- Handshake:
  - `dout` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_ready` while `out_valid`=0 has no effect.
- Reset (rst=0, asynchronous):
  - `bidx`=0, state IDLE, FIFO emptied.
  - Outputs: `out_valid`=0, `level`=0, `overflow`=0, `dout`=0.
  - Reset mid-word discards the partial word. Deassertion is synchronised externally.

## Timing
- Latency: final byte of a word at edge N gives `out_valid`=1 after edge N (visible cycle N+1) when the FIFO was empty.
- Throughput: one word per WORD_BYTES valid cycles. The FIFO sustains full rate with `out_ready` held high.
- `dout` is the registered FIFO head. No combinational path from any input to `dout`.
- `out_valid` and `level` depend only on registers. No combinational path from `out_ready` to `out_valid`.
- `overflow` updates on the edge of the drop and is visible the next cycle.

## Structure
- Shared package `ddr_pkg`:
  - `NIB_W`=4 and `BYTE_W`=8.
  - FIFO depth constant `OFIFO_DEPTH`=2.
  - Packer state enum {IDLE, FILL}.
- One sub-module, `word_fifo2`: 2-entry FIFO, width parameter, push/pop/level/full, asynchronous active-low reset. Instantiated once.
- Byte join, `bidx` counter, state machine and sticky overflow stay in the top level.

## Test plan
- **Reset:** assert `rst`=0 mid-word (after 1 of 2 bytes). `out_valid`=0, `level`=0, `overflow`=0. After release, the next 2 bytes form a fresh word.
- **Basic pack** (WORD_BYTES=2): drive pairs (lo=A, hi=3), then (lo=5, hi=C), `out_ready`=1. One cycle later `dout`=0xC53A, `out_valid`=1 for one cycle.
- **sof realign:** drive byte 0x11, then 0x22 with `sof`=1, then 0x33. Output is 0x3322. No word contains 0x11.
- **Backpressure/overflow:** hold `out_ready`=0 and push 3 words 0x0201, 0x0403, 0x0605. `level`=2, `overflow`=1, head stays 0x0201. Then release: outputs 0x0201, 0x0403. Pulse `clr_ovf`: `overflow`=0.
- **Full with simultaneous push+pop:** `level`=2 and `out_ready`=1 on the edge a new word 0x0807 completes. `level` stays 2. Output order is preserved, ending with 0x0807.
- **Gaps:** interleave `din_valid`=0 cycles between the bytes of a word. The word is still correct. `out_valid` appears one cycle after the final byte.
